// File: rtl/ahb_arbiter.sv
// ahb_arbiter
// Round-robin AHB bus arbiter. Shares one address/data path among NUM_MASTER
// masters, protects fixed-length bursts and locked sequences, and parks the
// bus on DEFAULT_MASTER when nobody requests.
//
// Ports:
//   hclk       bus clock, all state moves on the rising edge
//   hreset     asynchronous active-high reset
//   hbusreq    per-master bus request
//   hlock      per-master locked-transfer request
//   htrans     muxed bus HTRANS (IDLE/BUSY/NONSEQ/SEQ)
//   hburst     muxed bus HBURST
//   hready     muxed bus HREADY; every register holds while it is low
//   hgrant     registered one-hot grant
//   hmaster    registered index of the master owning the address phase
//   hmastlock  registered lock flag of the current address phase
module ahb_arbiter #(
  parameter int NUM_MASTER     = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTER)
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [NUM_MASTER-1:0] hbusreq,
  input  logic [NUM_MASTER-1:0] hlock,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  output logic [NUM_MASTER-1:0] hgrant,
  output logic [MW-1:0]         hmaster,
  output logic                  hmastlock
);

  localparam logic [1:0] HT_IDLE   = 2'd0;
  localparam logic [1:0] HT_BUSY   = 2'd1;
  localparam logic [1:0] HT_NONSEQ = 2'd2;
  localparam logic [1:0] HT_SEQ    = 2'd3;

  localparam logic [MW-1:0]         DEF_IDX    = MW'(DEFAULT_MASTER);
  localparam logic [MW:0]           NM_W       = (MW+1)'(NUM_MASTER);
  localparam logic [NUM_MASTER-1:0] ONE_W      = {{(NUM_MASTER-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTER-1:0] DEF_ONEHOT = ONE_W << DEF_IDX;

  // Remaining-beat preload for a NONSEQ; SINGLE and INCR are unprotected.
  function automatic logic [4:0] burst_load(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: burst_load = 5'd3;
      3'd4, 3'd5: burst_load = 5'd7;
      3'd6, 3'd7: burst_load = 5'd15;
      default:    burst_load = 5'd0;
    endcase
  endfunction

  logic [4:0]              cnt_r;
  logic [4:0]              cnt_nxt_s;
  logic [MW-1:0]           owner_r;
  logic [NUM_MASTER-1:0]   grant_r;
  logic [MW-1:0]           master_r;
  logic                    lock_r;
  logic [2*NUM_MASTER-1:0] rot_s;
  logic [MW:0]             cand_s;
  logic [MW-1:0]           sel_s;
  logic                    found_s;
  logic                    owner_lock_s;
  logic                    rearb_s;

  assign owner_lock_s = hlock[owner_r];

  // Next beat-counter value as it would be after a hready edge.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case (htrans)
      HT_NONSEQ: cnt_nxt_s = burst_load(hburst);
      HT_SEQ: begin
        if (cnt_r != 5'd0) begin
          cnt_nxt_s = cnt_r - 5'd1;
        end else begin
          cnt_nxt_s = 5'd0;
        end
      end
      HT_IDLE: cnt_nxt_s = 5'd0;
      HT_BUSY: cnt_nxt_s = cnt_r;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Bus may change hands only at the end of a protected burst, outside a
  // BUSY beat, and when the owner is not locking.
  assign rearb_s = (cnt_nxt_s == 5'd0) && (htrans != HT_BUSY) && !owner_lock_s;

  // Round-robin pick: rotate requests so bit 0 is owner+1 and the owner
  // itself lands in the top bit, then take the first set bit.
  always_comb begin
    rot_s   = {hbusreq, hbusreq} >> ({1'b0, owner_r} + {{MW{1'b0}}, 1'b1});
    sel_s   = DEF_IDX;
    found_s = 1'b0;
    cand_s  = {(MW+1){1'b0}};
    for (int k = 0; k < NUM_MASTER; k++) begin
      if (!found_s && rot_s[k]) begin
        found_s = 1'b1;
        cand_s  = {1'b0, owner_r} + (MW+1)'(k + 1);
        if (cand_s >= NM_W) begin
          sel_s = MW'(cand_s - NM_W);
        end else begin
          sel_s = cand_s[MW-1:0];
        end
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbitration state; everything freezes on hready = 0 edges.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cnt_r    <= 5'd0;
      owner_r  <= DEF_IDX;
      grant_r  <= DEF_ONEHOT;
      master_r <= DEF_IDX;
      lock_r   <= 1'b0;
    end else if (hready) begin
      cnt_r    <= cnt_nxt_s;
      master_r <= owner_r;
      lock_r   <= owner_lock_s;
      if (rearb_s) begin
        owner_r <= sel_s;
        grant_r <= ONE_W << sel_s;
      end
    end
  end

  assign hgrant    = grant_r;
  assign hmaster   = master_r;
  assign hmastlock = lock_r;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter (NUM_MASTER = 4, DEFAULT_MASTER = 0).
// The stimulus process drives inputs at the falling edge, advances a
// behavioural model of the arbitration rules and queues the outputs expected
// after the next rising edge (or after an asynchronous reset). A monitor
// process pops and compares after each rising edge / reset assertion.
module tb_ahb_arbiter;

  logic       hclk = 1'b0;
  logic       hreset = 1'b0;
  logic [3:0] hbusreq = 4'd0;
  logic [3:0] hlock = 4'd0;
  logic [1:0] htrans = 2'd0;
  logic [2:0] hburst = 3'd0;
  logic       hready = 1'b1;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // model state
  int   m_own;
  int   m_rem;
  int   m_master;
  logic m_lock;

  ahb_arbiter #(.NUM_MASTER(4), .DEFAULT_MASTER(0)) dut (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  function automatic exp_t model_out();
    exp_t e;
    e.g = 4'(4'd1 << m_own);
    e.m = 2'(m_master);
    e.l = m_lock;
    return e;
  endfunction

  task automatic model_reset();
    m_own = 0; m_rem = 0; m_master = 0; m_lock = 1'b0;
  endtask

  // One rising edge of the arbitration rules, evaluated on current inputs.
  task automatic model_edge();
    int len;
    int pick;
    if (hready) begin
      m_master = m_own;
      m_lock   = hlock[m_own];
      case (htrans)
        2'd2: begin
          len = (hburst >= 3'd6) ? 16 : (hburst >= 3'd4) ? 8 : (hburst >= 3'd2) ? 4 : 1;
          m_rem = len - 1;
        end
        2'd3: m_rem = (m_rem > 0) ? m_rem - 1 : 0;
        2'd0: m_rem = 0;
        default: m_rem = m_rem;
      endcase
      if (m_rem == 0 && htrans != 2'd1 && !hlock[m_own]) begin
        pick = 0;  // parking master when nobody asks
        for (int d = 4; d >= 1; d--) begin
          if (hbusreq[(m_own + d) % 4]) pick = (m_own + d) % 4;
        end
        m_own = pick;
      end
    end
    exp_q.push_back(model_out());
  endtask

  task automatic tick(input logic [3:0] req, input logic [3:0] lck,
                      input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    @(negedge hclk);
    hreset  = 1'b0;
    hbusreq = req; hlock = lck; htrans = tr; hburst = bu; hready = rdy;
    model_edge();
  endtask

  // Assert reset mid low phase, hold it over `hold` rising edges.
  task automatic async_reset(input int hold);
    @(negedge hclk);
    #2;
    model_reset();
    exp_q.push_back(model_out());
    hreset = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge hclk);
      exp_q.push_back(model_out());
    end
  endtask

  // Monitor: compare queued expectations against DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge hclk or posedge hreset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (hgrant !== e.g) begin
          bad++;
          $display("FAIL hgrant t=%0t: got %b want %b", $time, hgrant, e.g);
        end
        total++;
        if (hmaster !== e.m) begin
          bad++;
          $display("FAIL hmaster t=%0t: got %0d want %0d", $time, hmaster, e.m);
        end
        total++;
        if (hmastlock !== e.l) begin
          bad++;
          $display("FAIL hmastlock t=%0t: got %b want %b", $time, hmastlock, e.l);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    model_reset();
    // reset, then idle with no requests
    async_reset(2);
    for (int i = 0; i < 10; i++) tick(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1);

    // round robin on SINGLE transfers
    for (int i = 0; i < 8; i++) tick(4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1);

    // INCR8 by master 1, master 2 joins from beat 1
    async_reset(1);
    tick(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1);
    tick(4'b0110, 4'b0000, 2'd2, 3'd5, 1'b1);
    for (int i = 0; i < 7; i++) tick(4'b0110, 4'b0000, 2'd3, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) tick(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1);

    // INCR4 with 3 wait states on beat 2
    async_reset(1);
    tick(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1);
    tick(4'b0110, 4'b0000, 2'd2, 3'd3, 1'b1);
    for (int i = 0; i < 3; i++) tick(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) tick(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1);
    for (int i = 0; i < 3; i++) tick(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1);

    // locked SINGLE pair by master 3 while everyone requests
    tick(4'b1000, 4'b1000, 2'd0, 3'd0, 1'b1);
    tick(4'b1111, 4'b1000, 2'd2, 3'd0, 1'b1);
    tick(4'b1111, 4'b1000, 2'd2, 3'd0, 1'b1);
    tick(4'b1111, 4'b0000, 2'd0, 3'd0, 1'b1);
    tick(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1);

    // INCR16 abandoned with IDLE after 5 beats
    tick(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1);
    tick(4'b1100, 4'b0000, 2'd2, 3'd7, 1'b1);
    for (int i = 0; i < 4; i++) tick(4'b1100, 4'b0000, 2'd3, 3'd7, 1'b1);
    tick(4'b1100, 4'b0000, 2'd0, 3'd0, 1'b1);
    tick(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1);

    // reset asserted at beat 9 of an INCR16
    tick(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1);
    tick(4'b0011, 4'b0000, 2'd2, 3'd7, 1'b1);
    for (int i = 0; i < 8; i++) tick(4'b0011, 4'b0000, 2'd3, 3'd7, 1'b1);
    async_reset(2);
    for (int i = 0; i < 3; i++) tick(4'b0011, 4'b0000, 2'd0, 3'd0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick(4'($urandom_range(0, 15)),
           ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
           2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
    end

    @(negedge hclk);
    @(negedge hclk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter for the AHB_Gen interconnect. It shares one AHB address/data path among NUM_MASTER masters. It drives per-master grants plus `hmaster` and `hmastlock` toward the address/control multiplexer and the slaves. It protects fixed-length bursts and locked sequences, and parks the bus on a default master when nobody requests. It sits between the master agents (`mas_send_type` side) and the bus multiplexer that selects which master's request reaches the slaves.

## Interface
Parameters:
- NUM_MASTER, 4: number of requesting masters (2..16).
- DEFAULT_MASTER, 0: parking master index when no requests are pending.
- MW, $clog2(NUM_MASTER): width of `hmaster`.

Ports:
- hclk  in  1  bus clock; all state updates on the rising edge.
- hreset  in  1  asynchronous, active-high reset.
- hbusreq  in  NUM_MASTER  per-master bus request.
- hlock  in  NUM_MASTER  per-master locked-transfer request.
- htrans  in  2  muxed bus HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst  in  3  muxed bus HBURST (SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7).
- hready  in  1  muxed bus HREADY.
- hgrant  out  NUM_MASTER  one-hot grant, registered.
- hmaster  out  MW  index of the master owning the address phase, registered.
- hmastlock  out  1  current address phase is locked, registered.

## Operation
- Reset values: hgrant = one-hot(DEFAULT_MASTER), hmaster = DEFAULT_MASTER, hmastlock = 0, beat counter = 0, owner = DEFAULT_MASTER.
- Owner: the index currently asserted in hgrant.
- Beat counter (5 bits) tracks the remaining address beats of a fixed-length burst. It updates only on edges with hready = 1:
  - NONSEQ with hburst of length 4/8/16: load length-1 (3/7/15).
  - NONSEQ with SINGLE or INCR: load 0.
  - SEQ with counter > 0: decrement.
  - IDLE: clear to 0, which handles early burst termination (ERROR response or abandon).
  - BUSY: hold.
- Rearbitration is allowed on a hready = 1 edge when all of the following hold:
  - the post-update counter is 0;
  - htrans != BUSY;
  - hlock[owner] = 0.
- States (implicit in counter/lock):
  - FREE: counter 0, not locked. Rearbitration allowed.
  - BURST: counter > 0. Grant held.
  - LOCKED: hlock[owner] = 1. Grant held regardless of other requests.
- Selection when rearbitration is allowed:
  - Scan hbusreq round-robin starting at owner+1 modulo NUM_MASTER, ending with owner itself. The first requester wins.
  - If no bit of hbusreq is set, grant DEFAULT_MASTER (parking).
  - The owner keeps the grant only if no other master requests.
- INCR (undefined length) bursts are not protected. They may lose the grant at any allowed edge; this is AHB-legal and the master re-issues NONSEQ.
- hmaster: on every hready = 1 edge, hmaster <= owner as it was before that edge. hmastlock <= hlock[owner] on the same edge.
- On a hready = 0 edge: hgrant, hmaster, hmastlock and the counter all hold.

## Timing
- hgrant changes at most once per hready edge. A new grant is visible in the cycle after the deciding edge.
- Handover latency: the deciding edge at a burst's last address beat (t) moves hgrant to the new owner.
  - At edge t+1, if hready = 1, hmaster takes the new index.
  - The new master drives NONSEQ in cycle t+2.
  - Exactly one IDLE bus cycle separates the two masters when hready stays high.
- Wait states: each hready = 0 cycle delays the above by one cycle. The grant never changes while hready = 0.
- Simultaneous request and lock: a lock asserted by the owner on the deciding edge holds the grant. A lock from a non-owner has no effect until that master is granted.
- Reset mid-burst: all state returns immediately to reset values; the counter is discarded.
- Counter wrap: SEQ with counter = 0 leaves it at 0, with no underflow.

## Test plan
- Reset, no requests:
  - hreset pulse → hgrant = 4'b0001, hmaster = 0, hmastlock = 0.
  - These values hold for 10 cycles with hbusreq = 0.
- Round-robin, single transfers:
  - Stimulus: hbusreq = 4'b1111, owner = 0, every transfer SINGLE, hready = 1.
  - Required: grants rotate 0→1→2→3→0, one per allowed edge.
  - Required: hmaster follows hgrant one edge later.
- INCR8 protection:
  - Stimulus: master 1 owns the bus and issues NONSEQ+7×SEQ with hburst = 5; master 2 requests from beat 1.
  - Required: hgrant stays 4'b0010 through beat 7, switches to 4'b0100 on the edge of beat 8.
  - Required: hmaster = 2 one hready edge later.
- Wait states:
  - Stimulus: the same INCR4 with hready = 0 for 3 cycles on beat 2.
  - Required: hgrant, hmaster and the counter are frozen during the stall.
  - Required: handover occurs 3 cycles later than in the no-wait case.
- Lock:
  - Stimulus: master 3 holds hlock = 1 across two SINGLE transfers while masters 0–2 request.
  - Required: hgrant = 4'b1000 and hmastlock = 1 throughout.
  - Required: after hlock drops, the grant passes to master 0.
- Early termination:
  - Stimulus: an INCR16 is aborted with htrans = IDLE after 5 beats.
  - Required: the counter clears and another requester is granted on that edge.
- Reset asserted mid-burst:
  - Stimulus: reset during an INCR16 at beat 9.
  - Required: outputs return to reset values asynchronously.
